// File: rtl/bp_common_pkg.sv
// rtl/bp_common_pkg.sv - issue-width constant shared by the FE queue, scheduler and detector
package bp_common_pkg;

    // Entries presented to and popped by the scheduler per cycle
    localparam int bp_issue_width_gp = 2;

endpackage

// File: rtl/bp_fe_queue_dual_mem.sv
// rtl/bp_fe_queue_dual_mem.sv - els_p x width_p register file, 2 write ports, 2 async read ports
module bp_fe_queue_dual_mem #(
    parameter int width_p = 128,
    parameter int els_p   = 8,
    localparam int addr_w_lp = $clog2(els_p)
) (
    input  logic                 clk_i,
    input  logic                 w_v1_i,
    input  logic [addr_w_lp-1:0] w_addr1_i,
    input  logic [width_p-1:0]   w_data1_i,
    input  logic                 w_v2_i,
    input  logic [addr_w_lp-1:0] w_addr2_i,
    input  logic [width_p-1:0]   w_data2_i,
    input  logic [addr_w_lp-1:0] r_addr1_i,
    output logic [width_p-1:0]   r_data1_o,
    input  logic [addr_w_lp-1:0] r_addr2_i,
    output logic [width_p-1:0]   r_data2_o
);

    logic [width_p-1:0] r_mem [els_p];

    // Two write ports; the top guarantees distinct addresses when both fire
    always_ff @(posedge clk_i) begin
        if (w_v1_i) r_mem[w_addr1_i] <= w_data1_i;
        if (w_v2_i) r_mem[w_addr2_i] <= w_data2_i;
    end

    assign r_data1_o = r_mem[r_addr1_i];
    assign r_data2_o = r_mem[r_addr2_i];

endmodule

// File: rtl/bp_fe_queue_dual.sv
// rtl/bp_fe_queue_dual.sv - dual-issue FE->BE queue; optional empty-queue bypass via BP_FE_QUEUE_BYPASS_EN
module bp_fe_queue_dual
    import bp_common_pkg::*;
#(
    parameter int width_p = 128,
    parameter int els_p   = 8,
    localparam int ptr_w_lp = $clog2(els_p),
    localparam int cnt_w_lp = $clog2(els_p) + 1
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                clr_i,
    input  logic [width_p-1:0]  enq_data1_i,
    input  logic [width_p-1:0]  enq_data2_i,
    input  logic                enq_v1_i,
    input  logic                enq_v2_i,
    output logic                enq_ready_o,
    output logic [width_p-1:0]  deq_data1_o,
    output logic [width_p-1:0]  deq_data2_o,
    output logic                deq_v1_o,
    output logic                deq_v2_o,
    input  logic [1:0]          deq_yumi_i,
    output logic [cnt_w_lp-1:0] count_o
);

    logic [ptr_w_lp-1:0] r_rd_ptr;
    logic [ptr_w_lp-1:0] r_wr_ptr;
    logic [cnt_w_lp-1:0] r_count;

    logic                w_enq_ready;
    logic                w_fire1;
    logic                w_fire2;
    logic [1:0]          w_enq_cnt;
    logic                w_bypass;
    logic [1:0]          w_skip;
    logic [1:0]          w_rd_adv;
    logic                w_wen1;
    logic                w_wen2;
    logic [width_p-1:0]  w_wdata1;
    logic [ptr_w_lp-1:0] w_wr_ptr_p1;
    logic [ptr_w_lp-1:0] w_rd_ptr_p1;
    logic [width_p-1:0]  w_mem_data1;
    logic [width_p-1:0]  w_mem_data2;
    logic                w_mem_v1;
    logic                w_mem_v2;
    logic [1:0]          w_avail;

    // Ready is a function of registered occupancy only: room for a full dual enqueue
    assign w_enq_ready = (r_count <= cnt_w_lp'(els_p - 2));
    assign w_fire1     = w_enq_ready & enq_v1_i;
    assign w_fire2     = w_fire1 & enq_v2_i;
    assign w_enq_cnt   = {1'b0, w_fire1} + {1'b0, w_fire2};

`ifdef BP_FE_QUEUE_BYPASS_EN
    assign w_bypass = (r_count == '0) & ~clr_i;
`else
    assign w_bypass = 1'b0;
`endif

    // In bypass, popped entries come straight from the enq inputs: skip writing them
    // and leave rd_ptr alone, since they never landed in storage.
    assign w_skip   = w_bypass ? deq_yumi_i : 2'd0;
    assign w_rd_adv = w_bypass ? 2'd0 : deq_yumi_i;

    assign w_wr_ptr_p1 = r_wr_ptr + ptr_w_lp'(1);
    assign w_rd_ptr_p1 = r_rd_ptr + ptr_w_lp'(1);

    // Select which incoming entries are stored, packed from wr_ptr upward
    always_comb begin
        w_wen1   = 1'b0;
        w_wen2   = 1'b0;
        w_wdata1 = enq_data1_i;
        if (!clr_i) begin
            case (w_skip)
                2'd0: begin
                    w_wen1 = w_fire1;
                    w_wen2 = w_fire2;
                end
                2'd1: begin
                    w_wen1   = w_fire2;
                    w_wdata1 = enq_data2_i;
                end
                default: ;
            endcase
        end
    end

    bp_fe_queue_dual_mem #(
        .width_p (width_p),
        .els_p   (els_p)
    ) u_mem (
        .clk_i     (clk_i),
        .w_v1_i    (w_wen1),
        .w_addr1_i (r_wr_ptr),
        .w_data1_i (w_wdata1),
        .w_v2_i    (w_wen2),
        .w_addr2_i (w_wr_ptr_p1),
        .w_data2_i (enq_data2_i),
        .r_addr1_i (r_rd_ptr),
        .r_data1_o (w_mem_data1),
        .r_addr2_i (w_rd_ptr_p1),
        .r_data2_o (w_mem_data2)
    );

    // Pointer and occupancy update; flush wins over enq/deq
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (clr_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + ptr_w_lp'(w_rd_adv);
            r_wr_ptr <= r_wr_ptr + ptr_w_lp'(w_enq_cnt - w_skip);
            r_count  <= r_count + cnt_w_lp'(w_enq_cnt) - cnt_w_lp'(deq_yumi_i);
        end
    end

    assign w_mem_v1 = (r_count != '0);
    assign w_mem_v2 = (r_count > cnt_w_lp'(1));

    assign enq_ready_o = w_enq_ready;
    assign deq_v1_o    = w_bypass ? w_fire1 : w_mem_v1;
    assign deq_v2_o    = w_bypass ? w_fire2 : w_mem_v2;
    assign deq_data1_o = w_bypass ? enq_data1_i : w_mem_data1;
    assign deq_data2_o = w_bypass ? enq_data2_i : w_mem_data2;
    assign count_o     = r_count;

    assign w_avail = {1'b0, deq_v1_o} + {1'b0, deq_v2_o};

    a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (deq_yumi_i <= 2'(bp_issue_width_gp)) && (deq_yumi_i <= w_avail));

    a_enq_v2_needs_v1: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        enq_v2_i |-> enq_v1_i);

endmodule
